alu_seq: RTL and testbench

- Multi-byte operation sequencer that sits in front of the 8-bit combinational ALU.
- Takes one NBYTES-wide operation over a valid/ready request channel and issues one ALU command per byte, one byte per cycle.
- Chains shift/carry between byte phases and returns the full-width result, carry and zero over a valid/ready response channel.
- Instantiated next to the ALU in the datapath; its alu_* outputs drive the ALU inputs directly.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_seq.sv | 147 ++++++++++++++
 tb/tb_alu_seq.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU command encoding and sequencer state type
package alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_SHL = 4'd2;
  localparam logic [3:0] ALU_ASR = 4'd3;
  localparam logic [3:0] ALU_SHR = 4'd4;
  localparam logic [3:0] ALU_NOT = 4'd5;
  localparam logic [3:0] ALU_AND = 4'd6;
  localparam logic [3:0] ALU_XOR = 4'd7;
  localparam logic [3:0] ALU_MUL = 4'd8;

  typedef enum logic [1:0] {IDLE, RUN, RESP} seq_state_t;

  function automatic logic cmd_supported(input logic [3:0] cmd);
    case (cmd)
      ALU_ADD, ALU_SUB, ALU_SHL, ALU_ASR, ALU_SHR, ALU_AND, ALU_XOR: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Right shifts must walk MSB to LSB so the carry ripples downward.
  function automatic logic cmd_msb_first(input logic [3:0] cmd);
    return (cmd == ALU_ASR) || (cmd == ALU_SHR);
  endfunction

endpackage

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - multi-byte operation sequencer driving the 8-bit ALU
module alu_seq
  import alu_pkg::*;
#(
  parameter int NBYTES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [3:0]          req_cmd,
  input  logic [8*NBYTES-1:0] req_a,
  input  logic [8*NBYTES-1:0] req_b,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [8*NBYTES-1:0] rsp_data,
  output logic                rsp_carry,
  output logic                rsp_zero,
  output logic                rsp_err,
  output logic [3:0]          alu_cmd,
  output logic [7:0]          alu_a,
  output logic [7:0]          alu_b,
  output logic                alu_sc_i,
  input  logic [7:0]          alu_rslt,
  input  logic                alu_sc_o
);

  localparam int W = 8 * NBYTES;
  localparam logic [1:0] LAST = 2'(NBYTES - 1);

  seq_state_t     state_q, state_d;
  logic [3:0]     cmd_q;
  logic [W-1:0]   a_q, b_q, rslt_q;
  logic           carry_q, err_q;
  logic [1:0]     phase_q;
  logic [1:0]     lane;
  logic           first_phase, last_phase;
  logic [7:0]     a_byte, b_byte;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req_valid) state_d = cmd_supported(req_cmd) ? RUN : RESP;
      RUN:  if (last_phase) state_d = RESP;
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    first_phase = (phase_q == 2'd0);
    last_phase  = (phase_q == LAST);
    lane        = cmd_msb_first(cmd_q) ? (LAST - phase_q) : phase_q;
    a_byte      = 8'd0;
    b_byte      = 8'd0;
    for (int i = 0; i < NBYTES; i++) begin
      if (lane == 2'(i)) begin
        a_byte = a_q[i*8 +: 8];
        b_byte = b_q[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_q   <= 4'd0;
      a_q     <= '0;
      b_q     <= '0;
      rslt_q  <= '0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
      phase_q <= 2'd0;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          cmd_q   <= req_cmd;
          a_q     <= req_a;
          b_q     <= req_b;
          rslt_q  <= '0;
          carry_q <= 1'b0;
          err_q   <= ~cmd_supported(req_cmd);
          phase_q <= 2'd0;
        end
        RUN: begin
          for (int i = 0; i < NBYTES; i++) begin
            if (lane == 2'(i)) rslt_q[i*8 +: 8] <= alu_rslt;
          end
          carry_q <= (cmd_q == ALU_AND || cmd_q == ALU_XOR) ? 1'b0 : alu_sc_o;
          phase_q <= phase_q + 2'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == RESP);
    rsp_data  = rsp_valid ? rslt_q : '0;
    rsp_carry = rsp_valid & carry_q;
    rsp_zero  = rsp_valid & ~err_q & (rslt_q == '0);
    rsp_err   = rsp_valid & err_q;
    alu_cmd   = 4'd0;
    alu_a     = 8'd0;
    alu_b     = 8'd0;
    alu_sc_i  = 1'b0;
    if (state_q == RUN) begin
      alu_a = a_byte;
      case (cmd_q)
        ALU_ADD: begin
          alu_cmd  = ALU_ADD;
          alu_b    = b_byte;
          alu_sc_i = first_phase ? 1'b0 : carry_q;
        end
        // Subtract as A + ~B + 1 so the ALU only ever sees an add.
        ALU_SUB: begin
          alu_cmd  = ALU_ADD;
          alu_b    = ~b_byte;
          alu_sc_i = first_phase ? 1'b1 : carry_q;
        end
        ALU_SHL: begin
          alu_cmd  = ALU_SHL;
          alu_sc_i = first_phase ? 1'b0 : carry_q;
        end
        ALU_ASR: begin
          alu_cmd  = first_phase ? ALU_ASR : ALU_SHR;
          alu_sc_i = first_phase ? 1'b0 : carry_q;
        end
        ALU_SHR: begin
          alu_cmd  = ALU_SHR;
          alu_sc_i = first_phase ? 1'b0 : carry_q;
        end
        ALU_AND, ALU_XOR: begin
          alu_cmd = cmd_q;
          alu_b   = b_byte;
        end
        default: alu_a = 8'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed scoreboard bench for alu_seq with an 8-bit ALU model
module tb_alu_seq;

  typedef struct packed {
    logic [15:0] data;
    logic        carry;
    logic        zero;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_cmd = 4'd0;
  logic [15:0] req_a = 16'd0;
  logic [15:0] req_b = 16'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_data;
  logic        rsp_carry, rsp_zero, rsp_err;
  logic [3:0]  alu_cmd;
  logic [7:0]  alu_a, alu_b;
  logic        alu_sc_i;
  logic [7:0]  alu_rslt;
  logic        alu_sc_o;

  int   total = 0;
  int   bad = 0;
  int   cmd1_seen = 0;
  int   ncap = 0;
  logic [3:0] cap [4];
  exp_t sb [$];

  alu_seq #(.NBYTES(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .alu_cmd(alu_cmd), .alu_a(alu_a), .alu_b(alu_b), .alu_sc_i(alu_sc_i),
    .alu_rslt(alu_rslt), .alu_sc_o(alu_sc_o)
  );

  always #5 clk = ~clk;

  // Behavioural stand-in for the datapath ALU.
  always_comb begin
    logic [8:0] s;
    s        = 9'd0;
    alu_rslt = 8'd0;
    alu_sc_o = 1'b0;
    case (alu_cmd)
      4'd0: begin
        s = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_sc_i};
        alu_rslt = s[7:0];
        alu_sc_o = s[8];
      end
      4'd1: begin
        s = {1'b0, alu_a} - {1'b0, alu_b};
        alu_rslt = s[7:0];
        alu_sc_o = s[8];
      end
      4'd2: begin alu_rslt = {alu_a[6:0], alu_sc_i}; alu_sc_o = alu_a[7]; end
      4'd3: begin alu_rslt = {alu_a[7], alu_a[7:1]}; alu_sc_o = alu_a[0]; end
      4'd4: begin alu_rslt = {alu_sc_i, alu_a[7:1]}; alu_sc_o = alu_a[0]; end
      4'd5: alu_rslt = ~alu_a;
      4'd6: alu_rslt = alu_a & alu_b;
      4'd7: alu_rslt = alu_a ^ alu_b;
      default: alu_rslt = 8'd0;
    endcase
  end

  always @(negedge clk) if (alu_cmd == 4'd1) cmd1_seen++;

  function automatic exp_t model(input logic [3:0] c, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    logic [16:0] s;
    e = '0;
    case (c)
      4'd0: begin s = {1'b0, a} + {1'b0, b}; e.data = s[15:0]; e.carry = s[16]; end
      4'd1: begin e.data = a - b; e.carry = (a >= b); end
      4'd2: begin e.data = {a[14:0], 1'b0}; e.carry = a[15]; end
      4'd3: begin e.data = {a[15], a[15:1]}; e.carry = a[0]; end
      4'd4: begin e.data = {1'b0, a[15:1]}; e.carry = a[0]; end
      4'd6: e.data = a & b;
      4'd7: e.data = a ^ b;
      default: e.err = 1'b1;
    endcase
    e.zero = !e.err && (e.data == 16'd0);
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge in IDLE; returns at the negedge of cycle 1.
  task automatic issue(input logic [3:0] c, input logic [15:0] a, input logic [15:0] b, input bit push);
    if (push) sb.push_back(model(c, a, b));
    req_valid = 1'b1;
    req_cmd   = c;
    req_a     = a;
    req_b     = b;
    check("req_ready_idle", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    req_cmd   = 4'($urandom);
    req_a     = 16'($urandom);
    req_b     = 16'($urandom);
  endtask

  task automatic collect(input int exp_lat, input int hold, input bit preload,
                         input logic [3:0] pc, input logic [15:0] pa, input logic [15:0] pb);
    int   lat;
    exp_t e;
    lat  = 1;
    ncap = 0;
    while (!rsp_valid && lat < 40) begin
      if (ncap < 4) begin cap[ncap] = alu_cmd; ncap++; end
      @(negedge clk);
      lat++;
    end
    check("latency", lat, exp_lat);
    check("sb_nonempty", (sb.size() != 0), 1);
    e = (sb.size() != 0) ? sb.pop_front() : '0;
    check("rsp_data", rsp_data, e.data);
    check("rsp_carry", rsp_carry, e.carry);
    check("rsp_zero", rsp_zero, e.zero);
    check("rsp_err", rsp_err, e.err);
    if (preload) begin
      req_valid = 1'b1;
      req_cmd   = pc;
      req_a     = pa;
      req_b     = pb;
      sb.push_back(model(pc, pa, pb));
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("bp_valid", rsp_valid, 1);
      check("bp_data", rsp_data, e.data);
      check("bp_flags", {rsp_carry, rsp_zero, rsp_err}, {e.carry, e.zero, e.err});
      check("bp_req_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("post_rsp_valid", rsp_valid, 0);
    check("post_req_ready", req_ready, 1);
    if (preload) begin
      @(negedge clk);
      req_valid = 1'b0;
      req_a     = 16'($urandom);
      req_b     = 16'($urandom);
    end
  endtask

  initial begin
    logic [3:0] ops [7];
    int seen;
    ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd7};

    repeat (2) @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp", {rsp_valid, rsp_carry, rsp_zero, rsp_err}, 4'b0000);
    check("rst_rsp_data", rsp_data, 16'h0000);
    check("rst_alu", {alu_cmd, alu_a, alu_b, alu_sc_i}, 21'd0);
    reset = 1'b0;
    @(negedge clk);

    issue(4'd0, 16'h00FF, 16'h0001, 1); collect(3, 0, 0, 4'd0, 16'd0, 16'd0);
    issue(4'd0, 16'hFFFF, 16'h0001, 1); collect(3, 0, 0, 4'd0, 16'd0, 16'd0);
    issue(4'd1, 16'h1000, 16'h0001, 1); collect(3, 0, 0, 4'd0, 16'd0, 16'd0);
    check("sub_first_cmd", cap[0], 4'd0);
    issue(4'd1, 16'h0000, 16'h0001, 1); collect(3, 0, 0, 4'd0, 16'd0, 16'd0);
    issue(4'd2, 16'h8001, 16'h0000, 1); collect(3, 0, 0, 4'd0, 16'd0, 16'd0);
    issue(4'd4, 16'h8001, 16'h0000, 1); collect(3, 0, 0, 4'd0, 16'd0, 16'd0);
    issue(4'd3, 16'h8001, 16'h0000, 1); collect(3, 0, 0, 4'd0, 16'd0, 16'd0);
    check("asr_cmd_seq", {cap[0], cap[1]}, {4'd3, 4'd4});
    issue(4'd7, 16'hA5A5, 16'hA5A5, 1); collect(3, 0, 0, 4'd0, 16'd0, 16'd0);
    issue(4'd6, 16'hF0F0, 16'h3C3C, 1); collect(3, 0, 0, 4'd0, 16'd0, 16'd0);

    issue(4'd8, 16'h1234, 16'h5678, 1); collect(1, 0, 0, 4'd0, 16'd0, 16'd0);
    issue(4'd5, 16'h00FF, 16'h0000, 1); collect(1, 0, 0, 4'd0, 16'd0, 16'd0);
    issue(4'd15, 16'h0000, 16'h0000, 1); collect(1, 0, 0, 4'd0, 16'd0, 16'd0);

    issue(4'd0, 16'h1234, 16'h4321, 1); collect(3, 5, 1, 4'd1, 16'h5555, 16'hAAAA);
    collect(3, 0, 0, 4'd0, 16'd0, 16'd0);

    for (int i = 0; i < 8; i++) begin
      issue(ops[$urandom_range(6, 0)], 16'($urandom), 16'($urandom), 1);
      collect(3, 0, 0, 4'd0, 16'd0, 16'd0);
    end

    issue(4'd0, 16'h00FF, 16'h0001, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_req_ready", req_ready, 1);
    check("abort_rsp_valid", rsp_valid, 0);
    check("abort_alu", {alu_cmd, alu_a, alu_b, alu_sc_i}, 21'd0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("abort_no_rsp", seen, 0);

    check("alu_cmd1_never", cmd1_seen, 0);
    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
